// File: rtl/center_light.sv
// Center light cell of the tug-of-war playfield: one-bit Moore FSM that resets to lit.
// Optional CENTER_LIGHT_EDGE_DETECT_EN adds button synchronizers and rising-edge detection.
module center_light #(
    parameter logic RESET_STATE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic LeftButton,
    input  logic RightButton,
    input  logic LeftLEDR,
    input  logic RightLEDR,
    output logic lightOn
);

    localparam logic [0:0] OFF = 1'b0;
    localparam logic [0:0] ON  = 1'b1;

    logic [0:0] state_q, state_d;
    logic       left_press, right_press;

`ifdef CENTER_LIGHT_EDGE_DETECT_EN
    logic [1:0] left_sync_q, right_sync_q;
    logic       left_prev_q, right_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            left_sync_q  <= 2'b00;
            right_sync_q <= 2'b00;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
        end else begin
            left_sync_q  <= {left_sync_q[0], LeftButton};
            right_sync_q <= {right_sync_q[0], RightButton};
            left_prev_q  <= left_sync_q[1];
            right_prev_q <= right_sync_q[1];
        end
    end

    // One-cycle pulse per press, two cycles after the raw edge
    assign left_press  = left_sync_q[1] & ~left_prev_q;
    assign right_press = right_sync_q[1] & ~right_prev_q;
`else
    assign left_press  = LeftButton;
    assign right_press = RightButton;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ON: begin
                if (left_press != right_press) state_d = OFF;
            end
            default: begin
                if ((right_press && !left_press && LeftLEDR) ||
                    (left_press && !right_press && RightLEDR)) begin
                    state_d = ON;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    assign lightOn = state_q[0];

endmodule

// File: tb/tb_center_light.sv
// Randomized self-checking bench for center_light against a behavioural model of the
// tug-of-war rules (also models CENTER_LIGHT_EDGE_DETECT_EN when that macro is defined).
module tb_center_light;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic LeftButton = 1'b0;
    logic RightButton = 1'b0;
    logic LeftLEDR = 1'b0;
    logic RightLEDR = 1'b0;
    logic lightOn;

    int checks = 0;
    int failures = 0;

    // Model state: expected light and raw button history (index 0 = most recent edge)
    logic exp_on = 1'b1;
    logic [2:0] hist_l = 3'b000;
    logic [2:0] hist_r = 3'b000;

    center_light #(.RESET_STATE(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .LeftButton (LeftButton),
        .RightButton(RightButton),
        .LeftLEDR   (LeftLEDR),
        .RightLEDR  (RightLEDR),
        .lightOn    (lightOn)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: lightOn=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Predict the light after one edge from the game rules: a net pull from one side
    // moves the light away from a lit cell, or pulls it in from the lit neighbour.
    function automatic logic model_next(input logic on, input logic l, input logic r,
                                        input logic ll, input logic rl);
        int pull;
        pull = int'(r) - int'(l);  // >0 pulls rightward, <0 leftward
        if (on) return (pull == 0);
        if (pull > 0) return ll;
        if (pull < 0) return rl;
        return 1'b0;
    endfunction

    task automatic step(input string tag, input logic r_in, input logic l, input logic r,
                        input logic ll, input logic rl);
        logic eff_l, eff_r;
        reset = r_in;
        LeftButton = l;
        RightButton = r;
        LeftLEDR = ll;
        RightLEDR = rl;
`ifdef CENTER_LIGHT_EDGE_DETECT_EN
        // Press is seen by the FSM two edges after it was sampled, once per rising edge
        eff_l = hist_l[1] & ~hist_l[2];
        eff_r = hist_r[1] & ~hist_r[2];
`else
        eff_l = l;
        eff_r = r;
`endif
        if (r_in) begin
            exp_on = 1'b1;
            hist_l = 3'b000;
            hist_r = 3'b000;
        end else begin
            exp_on = model_next(exp_on, eff_l, eff_r, ll, rl);
            hist_l = {hist_l[1:0], l};
            hist_r = {hist_r[1:0], r};
        end
        @(posedge clock);
        #1;
        check(tag, lightOn, exp_on);
    endtask

    initial begin
        #2;
        // Reset, then idle
        step("reset", 1, 0, 0, 0, 0);
        check("reset_const", lightOn, 1'b1);
        for (int i = 0; i < 4; i++) step("idle_on", 0, 0, 0, 0, 0);
        // Neighbours lit, no buttons, then a right pull
        step("on_nbrs", 0, 0, 0, 1, 1);
        step("on_right", 0, 0, 1, 1, 1);
        // Held right pull with left neighbour lit
        for (int i = 0; i < 4; i++) step("toggle", 0, 0, 1, 1, 0);
        step("to_off", 1, 0, 0, 0, 0);
        step("to_off2", 0, 1, 0, 0, 0);
        step("to_off3", 0, 0, 0, 0, 0);
        step("to_off4", 0, 0, 0, 0, 0);
        step("to_off5", 0, 0, 0, 0, 0);
        // Left pull with right neighbour dark, then lit
        step("off_dark", 0, 1, 0, 1, 0);
        step("off_dark2", 0, 1, 0, 1, 0);
        step("off_lit", 0, 1, 0, 1, 1);
        // Both buttons
        step("rst_both", 1, 0, 0, 0, 0);
        step("on_both", 0, 1, 1, 1, 1);
        step("on_both2", 0, 1, 1, 1, 1);
        step("go_off", 0, 0, 1, 0, 0);
        step("go_off2", 0, 0, 0, 0, 0);
        step("go_off3", 0, 0, 0, 0, 0);
        step("off_both", 0, 1, 1, 1, 1);
        step("off_both2", 0, 1, 1, 1, 1);
        // Reset mid-game with buttons active
        step("mid_reset", 1, 0, 1, 1, 0);
        check("mid_reset_const", lightOn, 1'b1);
        // Held right press from OFF with left neighbour lit
        step("hold_prep", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("hold_prep2", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("hold_right", 0, 0, 1, 1, 0);
        // Randomized play
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
